pong_round_ctrl: RTL and testbench

Round sequencer for the pong game: it sequences paddle and ball datapaths through idle, serve, play, point and game-over phases. It generates the common movement tick and keeps both players' scores. It sits above the paddle FSM and ball logic and drives their reset and enable inputs. It consumes miss events from the ball logic and a START button.

---
 rtl/pong_round_ctrl.sv | 152 +++++++++++++++
 tb/tb_pong_round_ctrl.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/pong_round_ctrl.sv
// Pong round sequencer: idle/serve/play/point/game-over phases, movement tick
// generation and score keeping for both players.
module pong_round_ctrl #(
  parameter int unsigned TICK_DIV    = 1250000,
  parameter int unsigned SERVE_TICKS = 60,
  parameter int unsigned WIN_SCORE   = 5
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       START,
  input  logic       MISS_L,
  input  logic       MISS_R,
  output logic       TICK,
  output logic       PADDLE_RST,
  output logic       BALL_RST,
  output logic       PLAY_EN,
  output logic       SERVE_DIR,
  output logic [3:0] SCORE_L,
  output logic [3:0] SCORE_R,
  output logic [1:0] WINNER,
  output logic [2:0] STATE
);

  localparam int unsigned DIV_W = $clog2(TICK_DIV);
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(TICK_DIV - 1);
  localparam logic [7:0]       SERVE_LOAD = 8'(SERVE_TICKS);
  localparam logic [3:0]       WIN = 4'(WIN_SCORE);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_SERVE    = 3'd1,
    S_PLAY     = 3'd2,
    S_POINT    = 3'd3,
    S_GAMEOVER = 3'd4
  } state_t;

  state_t           state, state_nxt;
  logic [DIV_W-1:0] div_cnt, div_nxt;
  logic [7:0]       serve_cnt, serve_nxt;
  logic [3:0]       score_l_nxt, score_r_nxt;
  logic [1:0]       winner_nxt;
  logic             serve_dir_nxt;
  logic             start_q, start_edge;
  logic             tick_nxt, paddle_rst_nxt, ball_rst_nxt, play_en_nxt;

  assign start_edge = START & ~start_q;
  assign STATE      = state;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    state_nxt     = state;
    serve_nxt     = serve_cnt;
    score_l_nxt   = SCORE_L;
    score_r_nxt   = SCORE_R;
    winner_nxt    = WINNER;
    serve_dir_nxt = SERVE_DIR;
    div_nxt       = (div_cnt == DIV_MAX) ? '0 : div_cnt + DIV_W'(1);

    case (state)
      S_IDLE: begin
        score_l_nxt = '0;
        score_r_nxt = '0;
        winner_nxt  = 2'b00;
        if (start_edge) begin
          state_nxt = S_SERVE;
          serve_nxt = SERVE_LOAD;
        end
      end
      S_SERVE: begin
        // The zero test uses the registered count, so a zero load still spends one cycle here.
        if (serve_cnt == 8'd0) state_nxt = S_PLAY;
        else if (TICK)         serve_nxt = serve_cnt - 8'd1;
      end
      S_PLAY: begin
        if (MISS_L && MISS_R) begin
          state_nxt = S_SERVE;
          serve_nxt = SERVE_LOAD;
        end else if (MISS_R) begin
          if (SCORE_L < WIN) score_l_nxt = SCORE_L + 4'd1;
          serve_dir_nxt = 1'b1;
          state_nxt     = S_POINT;
        end else if (MISS_L) begin
          if (SCORE_R < WIN) score_r_nxt = SCORE_R + 4'd1;
          serve_dir_nxt = 1'b0;
          state_nxt     = S_POINT;
        end
      end
      S_POINT: begin
        if (SCORE_L == WIN) begin
          state_nxt  = S_GAMEOVER;
          winner_nxt = 2'b01;
        end else if (SCORE_R == WIN) begin
          state_nxt  = S_GAMEOVER;
          winner_nxt = 2'b10;
        end else begin
          state_nxt = S_SERVE;
          serve_nxt = SERVE_LOAD;
        end
      end
      S_GAMEOVER: begin
        if (start_edge) begin
          state_nxt     = S_SERVE;
          serve_nxt     = SERVE_LOAD;
          score_l_nxt   = '0;
          score_r_nxt   = '0;
          winner_nxt    = 2'b00;
          serve_dir_nxt = 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase

    // Outputs are decoded from the next state and registered, so they never glitch.
    tick_nxt       = (div_nxt == DIV_MAX);
    paddle_rst_nxt = (state_nxt == S_IDLE) || (state_nxt == S_POINT) ||
                     (state_nxt == S_GAMEOVER);
    ball_rst_nxt   = (state_nxt != S_PLAY);
    play_en_nxt    = (state_nxt == S_PLAY);
  end

  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments; reset here is synchronous.
    if (RST) begin
      state      <= S_IDLE;
      div_cnt    <= '0;
      serve_cnt  <= 8'd0;
      start_q    <= 1'b0;
      TICK       <= 1'b0;
      PADDLE_RST <= 1'b1;
      BALL_RST   <= 1'b1;
      PLAY_EN    <= 1'b0;
      SERVE_DIR  <= 1'b1;
      SCORE_L    <= 4'd0;
      SCORE_R    <= 4'd0;
      WINNER     <= 2'b00;
    end else begin
      state      <= state_nxt;
      div_cnt    <= div_nxt;
      serve_cnt  <= serve_nxt;
      start_q    <= START;
      TICK       <= tick_nxt;
      PADDLE_RST <= paddle_rst_nxt;
      BALL_RST   <= ball_rst_nxt;
      PLAY_EN    <= play_en_nxt;
      SERVE_DIR  <= serve_dir_nxt;
      SCORE_L    <= score_l_nxt;
      SCORE_R    <= score_r_nxt;
      WINNER     <= winner_nxt;
    end
  end

endmodule

// File: tb/tb_pong_round_ctrl.sv
// Directed bench for pong_round_ctrl with TICK_DIV=4, SERVE_TICKS=2, WIN_SCORE=3.
module tb_pong_round_ctrl;

  localparam int TICK_DIV    = 4;
  localparam int SERVE_TICKS = 2;
  localparam int WIN_SCORE   = 3;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       START = 1'b0;
  logic       MISS_L = 1'b0;
  logic       MISS_R = 1'b0;
  logic       TICK, PADDLE_RST, BALL_RST, PLAY_EN, SERVE_DIR;
  logic [3:0] SCORE_L, SCORE_R;
  logic [1:0] WINNER;
  logic [2:0] STATE;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;  // cycle number since the last reset release (cycle 1 = first)

  pong_round_ctrl #(
    .TICK_DIV   (TICK_DIV),
    .SERVE_TICKS(SERVE_TICKS),
    .WIN_SCORE  (WIN_SCORE)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .START     (START),
    .MISS_L    (MISS_L),
    .MISS_R    (MISS_R),
    .TICK      (TICK),
    .PADDLE_RST(PADDLE_RST),
    .BALL_RST  (BALL_RST),
    .PLAY_EN   (PLAY_EN),
    .SERVE_DIR (SERVE_DIR),
    .SCORE_L   (SCORE_L),
    .SCORE_R   (SCORE_R),
    .WINNER    (WINNER),
    .STATE     (STATE)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Advance one edge; TICK is expected on every cycle that is a multiple of TICK_DIV.
  task automatic step();
    @(posedge CLK);
    #1;
    cyc++;
    check("tick", 32'(TICK), 32'(cyc % TICK_DIV == 0));
  endtask

  task automatic run_until(input int c);
    while (cyc < c) step();
  endtask

  task automatic do_reset();
    RST = 1'b1;
    @(posedge CLK);
    #1;
    RST = 1'b0;
    cyc = 1;
  endtask

  task automatic pulse_miss(input logic l, input logic r);
    MISS_L = l;
    MISS_R = r;
    step();
    MISS_L = 1'b0;
    MISS_R = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_state"}, 32'(STATE), 0);
    check({tag, "_tick"},  32'(TICK), 0);
    check({tag, "_prst"},  32'(PADDLE_RST), 1);
    check({tag, "_brst"},  32'(BALL_RST), 1);
    check({tag, "_play"},  32'(PLAY_EN), 0);
    check({tag, "_dir"},   32'(SERVE_DIR), 1);
    check({tag, "_sl"},    32'(SCORE_L), 0);
    check({tag, "_sr"},    32'(SCORE_R), 0);
    check({tag, "_win"},   32'(WINNER), 0);
  endtask

  // Entered SERVE in cycle 'entry': the count falls to zero on the second tick
  // at or after entry, one more cycle is spent in SERVE, then PLAY.
  task automatic serve_then_play(input int entry);
    int t1, p;
    t1 = ((entry + TICK_DIV - 1) / TICK_DIV) * TICK_DIV;
    p  = t1 + (SERVE_TICKS - 1) * TICK_DIV + 2;
    run_until(p - 1);
    check("serve_last", 32'(STATE), 1);
    step();
    check("play_state", 32'(STATE), 2);
    check("play_en",    32'(PLAY_EN), 1);
    check("play_brst",  32'(BALL_RST), 0);
    check("play_prst",  32'(PADDLE_RST), 0);
  endtask

  initial begin
    // Reset and free-running tick (cycles 4, 8, 12)
    do_reset();
    check_reset_vals("rst");
    run_until(12);

    // Start edge, then START held through serve and play
    step();               // cycle 13
    START = 1'b1;
    step();               // cycle 14
    check("start_serve", 32'(STATE), 1);
    check("serve_brst",  32'(BALL_RST), 1);
    check("serve_prst",  32'(PADDLE_RST), 0);
    serve_then_play(14);  // PLAY at cycle 22
    step();
    check("held_start", 32'(STATE), 2);
    START = 1'b0;

    // Point to the left player
    pulse_miss(1'b0, 1'b1);
    check("pt1_state", 32'(STATE), 3);
    check("pt1_sl",    32'(SCORE_L), 1);
    check("pt1_dir",   32'(SERVE_DIR), 1);
    check("pt1_prst",  32'(PADDLE_RST), 1);
    step();
    check("pt1_serve", 32'(STATE), 1);
    serve_then_play(cyc);

    // Point to the right player
    pulse_miss(1'b1, 1'b0);
    check("pt2_state", 32'(STATE), 3);
    check("pt2_sr",    32'(SCORE_R), 1);
    check("pt2_dir",   32'(SERVE_DIR), 0);
    step();
    check("pt2_serve", 32'(STATE), 1);

    // Misses during SERVE are ignored
    begin
      int entry;
      entry = cyc;
      pulse_miss(1'b0, 1'b1);
      pulse_miss(1'b1, 1'b0);
      check("srv_miss_state", 32'(STATE), 1);
      check("srv_miss_sl",    32'(SCORE_L), 1);
      check("srv_miss_sr",    32'(SCORE_R), 1);
      serve_then_play(entry);
    end

    // Simultaneous misses go straight back to SERVE without scoring
    pulse_miss(1'b1, 1'b1);
    check("both_state", 32'(STATE), 1);
    check("both_sl",    32'(SCORE_L), 1);
    check("both_sr",    32'(SCORE_R), 1);
    check("both_dir",   32'(SERVE_DIR), 0);
    serve_then_play(cyc);

    // Two more left points end the game at 3
    pulse_miss(1'b0, 1'b1);
    check("pt3_sl", 32'(SCORE_L), 2);
    step();
    check("pt3_serve", 32'(STATE), 1);
    serve_then_play(cyc);
    pulse_miss(1'b0, 1'b1);
    check("pt4_state", 32'(STATE), 3);
    check("pt4_sl",    32'(SCORE_L), 3);
    step();
    check("go_state",  32'(STATE), 4);
    check("go_winner", 32'(WINNER), 1);
    check("go_prst",   32'(PADDLE_RST), 1);
    check("go_brst",   32'(BALL_RST), 1);
    check("go_play",   32'(PLAY_EN), 0);

    // Misses in GAMEOVER change nothing
    pulse_miss(1'b0, 1'b1);
    pulse_miss(1'b1, 1'b0);
    check("go_miss_state", 32'(STATE), 4);
    check("go_miss_sl",    32'(SCORE_L), 3);
    check("go_miss_sr",    32'(SCORE_R), 1);
    check("go_miss_win",   32'(WINNER), 1);

    // Restart from GAMEOVER
    START = 1'b1;
    step();
    START = 1'b0;
    check("rs_state", 32'(STATE), 1);
    check("rs_sl",    32'(SCORE_L), 0);
    check("rs_sr",    32'(SCORE_R), 0);
    check("rs_win",   32'(WINNER), 0);
    check("rs_dir",   32'(SERVE_DIR), 1);
    serve_then_play(cyc);

    // Two right points, then reset while in PLAY
    pulse_miss(1'b1, 1'b0);
    step();
    serve_then_play(cyc);
    pulse_miss(1'b1, 1'b0);
    check("pt6_sr", 32'(SCORE_R), 2);
    step();
    serve_then_play(cyc);
    check("pre_rst_sr", 32'(SCORE_R), 2);
    do_reset();
    check_reset_vals("mid_rst");
    run_until(9);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
